multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle FSM that sequences the shared MIPS-subset datapath: one ALU, register file, PC and IR.
- Each instruction runs as IF→ID→EX[→MEM][→WB]. Instruction and data memories are separate and wait-state capable, each with a req/ready handshake.
- Select and ALU encodings match the single-cycle decoder, so the datapath muxes are reused unchanged.
- Also counts retired instructions and flags illegal encodings.

Parameters:
- CNT_W, 32, width of the retired-instruction counter Inst_Count.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- OP  in  6  IR[31:26]; held stable by the datapath after IR_Write.
- func  in  6  IR[5:0].
- ZF  in  1  ALU zero flag, valid combinationally in EX.
- Inst_Ready  in  1  instruction memory ack: IR data valid this cycle.
- Data_Ready  in  1  data memory ack: load data valid / store accepted this cycle.
- Inst_Req  out  1  instruction fetch request.
- Data_Req  out  1  data access request.
- Mem_Write  out  1  data access is a store (qualifies Data_Req).
- IR_Write  out  1  load IR from instruction memory.
- PC_Write  out  1  load PC from the PC_s mux.
- PC_s  out  2  PC source: 00 PC+4, 01 rs (JR), 10 branch target, 11 jump target.
- Write_Reg  out  1  register file write enable.
- w_r_s  out  2  destination register: 00 rd, 01 rt, 10 $31.
- wr_data_s  out  2  write-back data: 00 ALUOut, 01 MDR, 10 PC.
- imm_s  out  1  immediate extension: 1 sign, 0 zero.
- rt_imm_s  out  1  ALU B input: 0 rt, 1 immediate.
- ALU_OP  out  3  100 add, 101 sub, 000 and, 001 or, 010 xor, 011 nor, 110 sltu, 111 sllv.
- Illegal_Inst  out  1  one-cycle pulse in ID for an unsupported OP/func.
- Inst_Count  out  CNT_W  retired-instruction counter.
- State  out  3  current state, for debug.

Behaviour:
- States and encodings: INIT=0, IF=1, ID=2, EX=3, MEM=4, WB=5.
- Reset (async): state←INIT and Inst_Count←0 immediately; any pending request is dropped.
- All outputs are Moore/Mealy-decoded from state, OP, func, ZF and the ready inputs.
- Every output not listed as active for the current state is driven 0; no X values are ever driven.
- INIT: all outputs 0; unconditionally →IF on the next edge.
- IF: Inst_Req=1. While Inst_Ready=0, stay in IF with no enables.
- IF with Inst_Ready=1: IR_Write=1, PC_Write=1, PC_s=00, →ID.
- ID: decode only.
  - Legal codes: R-type with func ∈ {ADD, SUB, AND, OR, XOR, NOR, SLTU, SLLV, JR}; ADDI, ANDI, XORI, SLTIU, LW, SW, BEQ, BNE, J, JAL.
  - Legal →EX. Illegal: Illegal_Inst=1, →IF, no count.
- EX: ALU controls per instruction.
  - R-type non-JR: rt_imm_s=0, ALU_OP from func, →WB.
  - ADDI: imm_s=1, rt_imm_s=1, add, →WB.
  - ANDI/XORI/SLTIU: imm_s=0, rt_imm_s=1, and/xor/sltu, →WB.
  - LW/SW: imm_s=1, rt_imm_s=1, add, →MEM.
  - BEQ: sub, rt_imm_s=0, PC_Write=ZF, PC_s=10, →IF, retire.
  - BNE: sub, rt_imm_s=0, PC_Write=~ZF, PC_s=10, →IF, retire.
  - JR: ALU_OP=add, PC_Write=1, PC_s=01, →IF, retire.
  - J: PC_Write=1, PC_s=11, →IF, retire.
  - JAL: PC_Write=1, PC_s=11, Write_Reg=1, w_r_s=10, wr_data_s=10, →IF, retire. The register file captures PC (already PC+4) on the same edge the PC updates.
- MEM: Data_Req=1 and the EX ALU controls are held (address stable); Mem_Write=1 for SW.
  - Stay in MEM until Data_Ready=1.
  - LW →WB. SW →IF, retire.
- WB: Write_Reg=1, EX ALU controls held, →IF, retire.
  - R-type: w_r_s=00, wr_data_s=00.
  - I-type ALU: w_r_s=01, wr_data_s=00.
  - LW: w_r_s=01, wr_data_s=01.
- Retire: Inst_Count increments on the edge that leaves the instruction's final state; it wraps modulo 2^CNT_W.
- Handshakes:
  - Req stays asserted and its address stays stable until the matching Ready is sampled high.
  - Ready without Req is ignored.
  - Ready in the same cycle Req first rises is a valid zero-wait access.
- Latency, zero wait states:
  - Branch/J/JAL/JR: 3 cycles.
  - R-type and I-type ALU: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- Reset asserted mid-MEM: Data_Req and Mem_Write fall asynchronously; no write completes.

Test Plan:
- Release rst_n, Inst_Ready=1 stuck → INIT one cycle, then IF with IR_Write=PC_Write=1, PC_s=00; Inst_Count=0.
- ADD (OP=0, func=100000), zero-wait → states 1,2,3,5,1; ALU_OP=100 in EX/WB; Write_Reg=1, w_r_s=00 only in WB; Inst_Count=1.
- LW with Data_Ready low 3 cycles → 3 extra MEM cycles with Data_Req=1, Mem_Write=0; WB has wr_data_s=01, w_r_s=01; 8 cycles total.
- BEQ with ZF=1 → PC_Write=1, PC_s=10 in EX. BNE with ZF=1 → PC_Write=0. Both retire.
- JAL → single EX cycle with PC_s=11, PC_Write=1, Write_Reg=1, w_r_s=10, wr_data_s=10. OP=111111 → Illegal_Inst pulse in ID, return to IF, count unchanged.
- SW with rst_n dropped mid-MEM → Data_Req and Mem_Write go 0 immediately, State=0, Inst_Count=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the shared MIPS-subset datapath.
// Ports: clk/rst_n; OP/func/ZF from IR/ALU; Inst/Data ready acks in;
//   memory requests, datapath enables/selects, Illegal_Inst,
//   Inst_Count (retired instructions) and State (debug) out.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       OP,
    input  logic [5:0]       func,
    input  logic             ZF,
    input  logic             Inst_Ready,
    input  logic             Data_Ready,
    output logic             Inst_Req,
    output logic             Data_Req,
    output logic             Mem_Write,
    output logic             IR_Write,
    output logic             PC_Write,
    output logic [1:0]       PC_s,
    output logic             Write_Reg,
    output logic [1:0]       w_r_s,
    output logic [1:0]       wr_data_s,
    output logic             imm_s,
    output logic             rt_imm_s,
    output logic [2:0]       ALU_OP,
    output logic             Illegal_Inst,
    output logic [CNT_W-1:0] Inst_Count,
    output logic [2:0]       State
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_JR   = 6'b001000;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             retire;

    logic       is_r;
    logic       is_jr;
    logic       is_alui;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic       legal;
    logic [2:0] alu_sel;
    logic       imm_sign;
    logic       use_imm;

    // Instruction class and ALU controls; IR is stable from ID onwards,
    // so MEM and WB re-use this decode to hold the EX ALU setup.
    always_comb begin
        is_r     = 1'b0;
        is_jr    = 1'b0;
        is_alui  = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        alu_sel  = 3'b000;
        imm_sign = 1'b0;
        use_imm  = 1'b0;
        case (OP)
            OP_RTYPE: begin
                case (func)
                    F_ADD:  begin is_r = 1'b1; alu_sel = ALU_ADD;  end
                    F_SUB:  begin is_r = 1'b1; alu_sel = ALU_SUB;  end
                    F_AND:  begin is_r = 1'b1; alu_sel = ALU_AND;  end
                    F_OR:   begin is_r = 1'b1; alu_sel = ALU_OR;   end
                    F_XOR:  begin is_r = 1'b1; alu_sel = ALU_XOR;  end
                    F_NOR:  begin is_r = 1'b1; alu_sel = ALU_NOR;  end
                    F_SLTU: begin is_r = 1'b1; alu_sel = ALU_SLTU; end
                    F_SLLV: begin is_r = 1'b1; alu_sel = ALU_SLLV; end
                    F_JR:   begin is_jr = 1'b1; alu_sel = ALU_ADD; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                is_alui  = 1'b1;
                alu_sel  = ALU_ADD;
                imm_sign = 1'b1;
                use_imm  = 1'b1;
            end
            OP_ANDI: begin
                is_alui = 1'b1;
                alu_sel = ALU_AND;
                use_imm = 1'b1;
            end
            OP_XORI: begin
                is_alui = 1'b1;
                alu_sel = ALU_XOR;
                use_imm = 1'b1;
            end
            OP_SLTIU: begin
                is_alui = 1'b1;
                alu_sel = ALU_SLTU;
                use_imm = 1'b1;
            end
            OP_LW: begin
                is_lw    = 1'b1;
                alu_sel  = ALU_ADD;
                imm_sign = 1'b1;
                use_imm  = 1'b1;
            end
            OP_SW: begin
                is_sw    = 1'b1;
                alu_sel  = ALU_ADD;
                imm_sign = 1'b1;
                use_imm  = 1'b1;
            end
            OP_BEQ: begin
                is_beq  = 1'b1;
                alu_sel = ALU_SUB;
            end
            OP_BNE: begin
                is_bne  = 1'b1;
                alu_sel = ALU_SUB;
            end
            OP_J:   is_j   = 1'b1;
            OP_JAL: is_jal = 1'b1;
            default: ;
        endcase
    end

    assign legal = is_r | is_jr | is_alui | is_lw | is_sw |
                   is_beq | is_bne | is_j | is_jal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (retire) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_comb begin
        state_next   = state;
        retire       = 1'b0;
        Inst_Req     = 1'b0;
        Data_Req     = 1'b0;
        Mem_Write    = 1'b0;
        IR_Write     = 1'b0;
        PC_Write     = 1'b0;
        PC_s         = 2'b00;
        Write_Reg    = 1'b0;
        w_r_s        = 2'b00;
        wr_data_s    = 2'b00;
        imm_s        = 1'b0;
        rt_imm_s     = 1'b0;
        ALU_OP       = 3'b000;
        Illegal_Inst = 1'b0;
        case (state)
            S_INIT: state_next = S_IF;
            S_IF: begin
                Inst_Req = 1'b1;
                if (Inst_Ready) begin
                    IR_Write   = 1'b1;
                    PC_Write   = 1'b1;
                    state_next = S_ID;
                end
            end
            S_ID: begin
                if (legal) begin
                    state_next = S_EX;
                end else begin
                    Illegal_Inst = 1'b1;
                    state_next   = S_IF;
                end
            end
            S_EX: begin
                ALU_OP   = alu_sel;
                imm_s    = imm_sign;
                rt_imm_s = use_imm;
                if (is_r || is_alui) begin
                    state_next = S_WB;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else begin
                    // Control transfers finish here; JAL's link write
                    // lands on the same edge as the PC update.
                    state_next = S_IF;
                    retire     = 1'b1;
                    unique case (1'b1)
                        is_beq: begin
                            PC_Write = ZF;
                            PC_s     = 2'b10;
                        end
                        is_bne: begin
                            PC_Write = ~ZF;
                            PC_s     = 2'b10;
                        end
                        is_jr: begin
                            PC_Write = 1'b1;
                            PC_s     = 2'b01;
                        end
                        is_j: begin
                            PC_Write = 1'b1;
                            PC_s     = 2'b11;
                        end
                        is_jal: begin
                            PC_Write  = 1'b1;
                            PC_s      = 2'b11;
                            Write_Reg = 1'b1;
                            w_r_s     = 2'b10;
                            wr_data_s = 2'b10;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                Data_Req  = 1'b1;
                Mem_Write = is_sw;
                ALU_OP    = alu_sel;
                imm_s     = imm_sign;
                rt_imm_s  = use_imm;
                if (Data_Ready) begin
                    if (is_lw) begin
                        state_next = S_WB;
                    end else begin
                        state_next = S_IF;
                        retire     = 1'b1;
                    end
                end
            end
            S_WB: begin
                Write_Reg  = 1'b1;
                ALU_OP     = alu_sel;
                imm_s      = imm_sign;
                rt_imm_s   = use_imm;
                w_r_s      = is_r ? 2'b00 : 2'b01;
                wr_data_s  = is_lw ? 2'b01 : 2'b00;
                state_next = S_IF;
                retire     = 1'b1;
            end
            default: state_next = S_INIT;
        endcase
    end

    assign Inst_Count = cnt;
    assign State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against a per-cycle
// expectation model built from instruction kind and wait counts.
module tb_multicycle_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    OP = '0;
    logic [5:0]    func = '0;
    logic          ZF = 1'b0;
    logic          Inst_Ready = 1'b0;
    logic          Data_Ready = 1'b0;
    logic          Inst_Req;
    logic          Data_Req;
    logic          Mem_Write;
    logic          IR_Write;
    logic          PC_Write;
    logic [1:0]    PC_s;
    logic          Write_Reg;
    logic [1:0]    w_r_s;
    logic [1:0]    wr_data_s;
    logic          imm_s;
    logic          rt_imm_s;
    logic [2:0]    ALU_OP;
    logic          Illegal_Inst;
    logic [CW-1:0] Inst_Count;
    logic [2:0]    State;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .OP(OP), .func(func), .ZF(ZF),
        .Inst_Ready(Inst_Ready), .Data_Ready(Data_Ready),
        .Inst_Req(Inst_Req), .Data_Req(Data_Req),
        .Mem_Write(Mem_Write), .IR_Write(IR_Write),
        .PC_Write(PC_Write), .PC_s(PC_s), .Write_Reg(Write_Reg),
        .w_r_s(w_r_s), .wr_data_s(wr_data_s), .imm_s(imm_s),
        .rt_imm_s(rt_imm_s), .ALU_OP(ALU_OP),
        .Illegal_Inst(Illegal_Inst), .Inst_Count(Inst_Count),
        .State(State)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ireq;
        logic       dreq;
        logic       mw;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       wreg;
        logic [1:0] wrs;
        logic [1:0] wds;
        logic       imm;
        logic       rti;
        logic [2:0] alu;
        logic       ill;
    } outs_t;

    outs_t obs;
    assign obs = {State, Inst_Req, Data_Req, Mem_Write, IR_Write,
                  PC_Write, PC_s, Write_Reg, w_r_s, wr_data_s,
                  imm_s, rt_imm_s, ALU_OP, Illegal_Inst};

    localparam int K_ILL = 0, K_R = 1, K_JR = 2, K_ADDI = 3;
    localparam int K_ANDI = 4, K_XORI = 5, K_SLTIU = 6, K_LW = 7;
    localparam int K_SW = 8, K_BEQ = 9, K_BNE = 10, K_J = 11;
    localparam int K_JAL = 12;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // R-type ALU code by func; 8 means not an R-type ALU op.
    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4;
            6'b100010: return 5;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b100110: return 2;
            6'b100111: return 3;
            6'b101011: return 6;
            6'b000100: return 7;
            default:   return 8;
        endcase
    endfunction

    function automatic int kind_of(input logic [5:0] op,
                                   input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) return K_JR;
                if (r_alu(fn) < 8) return K_R;
                return K_ILL;
            end
            6'b001000: return K_ADDI;
            6'b001100: return K_ANDI;
            6'b001110: return K_XORI;
            6'b001011: return K_SLTIU;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000101: return K_BNE;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    // Expected {alu, imm_s, rt_imm_s} for an instruction kind.
    function automatic logic [4:0] alu_info(input int k,
                                            input logic [5:0] fn);
        logic [2:0] a;
        a = 3'(r_alu(fn));
        case (k)
            K_R:          return {a, 2'b00};
            K_JR:         return 5'b100_00;
            K_ADDI:       return 5'b100_11;
            K_ANDI:       return 5'b000_01;
            K_XORI:       return 5'b010_01;
            K_SLTIU:      return 5'b110_01;
            K_LW, K_SW:   return 5'b100_11;
            K_BEQ, K_BNE: return 5'b101_00;
            default:      return 5'b000_00;
        endcase
    endfunction

    function automatic outs_t idle(input int st);
        outs_t e;
        e = '0;
        e.st = 3'(st);
        return e;
    endfunction

    function automatic outs_t with_alu(input int st, input int k,
                                       input logic [5:0] fn);
        outs_t e;
        logic [4:0] ai;
        e = idle(st);
        ai = alu_info(k, fn);
        e.alu = ai[4:2];
        e.imm = ai[1];
        e.rti = ai[0];
        return e;
    endfunction

    task automatic noise();
        Inst_Ready = 1'($urandom);
        Data_Ready = 1'($urandom);
        ZF = 1'($urandom);
    endtask

    task automatic step(input string tag, input outs_t e);
        #1;
        chk(tag, 32'(obs), 32'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic retire_one();
        model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic fetch(input int iw);
        outs_t e;
        repeat (iw) begin
            noise();
            Inst_Ready = 1'b0;
            OP = 6'($urandom);
            func = 6'($urandom);
            e = idle(1);
            e.ireq = 1'b1;
            step("if_wait", e);
        end
        noise();
        Inst_Ready = 1'b1;
        e = idle(1);
        e.ireq = 1'b1;
        e.irw = 1'b1;
        e.pcw = 1'b1;
        step("if_fetch", e);
    endtask

    // zfm: 0/1 forces ZF in EX, anything else leaves it random.
    task automatic run_inst(input logic [5:0] op, input logic [5:0] fn,
                            input int iw, input int dw, input int zfm);
        int k;
        outs_t e;
        k = kind_of(op, fn);
        fetch(iw);
        OP = op;
        func = fn;
        noise();
        e = idle(2);
        e.ill = (k == K_ILL);
        step("id", e);
        if (k != K_ILL) begin
            noise();
            if (zfm == 0 || zfm == 1) ZF = 1'(zfm);
            e = with_alu(3, k, fn);
            case (k)
                K_BEQ: begin e.pcw = ZF; e.pcs = 2'b10; end
                K_BNE: begin e.pcw = ~ZF; e.pcs = 2'b10; end
                K_JR:  begin e.pcw = 1'b1; e.pcs = 2'b01; end
                K_J:   begin e.pcw = 1'b1; e.pcs = 2'b11; end
                K_JAL: begin
                    e.pcw = 1'b1; e.pcs = 2'b11; e.wreg = 1'b1;
                    e.wrs = 2'b10; e.wds = 2'b10;
                end
                default: ;
            endcase
            step("ex", e);
            if (k == K_LW || k == K_SW) begin
                e = with_alu(4, k, fn);
                e.dreq = 1'b1;
                e.mw = (k == K_SW);
                repeat (dw) begin
                    noise();
                    Data_Ready = 1'b0;
                    step("mem_wait", e);
                end
                noise();
                Data_Ready = 1'b1;
                step("mem", e);
            end
            if (k == K_R || k == K_LW || (k >= K_ADDI && k <= K_SLTIU)) begin
                noise();
                e = with_alu(5, k, fn);
                e.wreg = 1'b1;
                e.wrs = (k == K_R) ? 2'b00 : 2'b01;
                e.wds = (k == K_LW) ? 2'b01 : 2'b00;
                step("wb", e);
            end
            retire_one();
        end
        #1;
        chk("count", 32'(Inst_Count), 32'(model_cnt));
    endtask

    logic [5:0] legal_ops [10];
    logic [5:0] legal_fns [9];

    initial begin
        outs_t e;
        legal_ops = '{6'b000000, 6'b001000, 6'b001100, 6'b001110,
                      6'b001011, 6'b100011, 6'b101011, 6'b000100,
                      6'b000101, 6'b000010};
        legal_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                      6'b100110, 6'b100111, 6'b101011, 6'b000100,
                      6'b001000};

        // reset state
        #12;
        chk("rst_outs", 32'(obs), 32'(idle(0)));
        chk("rst_count", 32'(Inst_Count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        Inst_Ready = 1'b1;
        step("init", idle(0));

        // directed
        run_inst(6'b000000, 6'b100000, 0, 0, 2);
        run_inst(6'b100011, 6'($urandom), 0, 3, 2);
        run_inst(6'b000100, 6'($urandom), 0, 0, 1);
        run_inst(6'b000101, 6'($urandom), 0, 0, 1);
        run_inst(6'b000000, 6'b001000, 1, 0, 2);
        run_inst(6'b000011, 6'($urandom), 0, 0, 2);
        run_inst(6'b111111, 6'($urandom), 0, 0, 2);
        run_inst(6'b000000, 6'b000001, 2, 0, 2);
        run_inst(6'b101011, 6'($urandom), 0, 0, 2);

        // SW aborted by reset while waiting in MEM
        fetch(0);
        OP = 6'b101011;
        func = 6'($urandom);
        noise();
        step("sw_id", idle(2));
        noise();
        step("sw_ex", with_alu(3, K_SW, func));
        e = with_alu(4, K_SW, func);
        e.dreq = 1'b1;
        e.mw = 1'b1;
        noise();
        Data_Ready = 1'b0;
        step("sw_mem_wait", e);
        noise();
        Data_Ready = 1'b0;
        #1;
        chk("sw_mem_hold", 32'(obs), 32'(e));
        #2;
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        chk("abort_dreq", 32'(Data_Req), 32'd0);
        chk("abort_mw", 32'(Mem_Write), 32'd0);
        chk("abort_state", 32'(State), 32'd0);
        chk("abort_count", 32'(Inst_Count), 32'(model_cnt));
        @(negedge clk);
        rst_n = 1'b1;
        noise();
        step("init2", idle(0));

        // random mix, including wrap of the narrow counter
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int sel;
            sel = int'($urandom_range(0, 11));
            fn = 6'($urandom);
            if (sel < 10) begin
                op = legal_ops[sel];
                if (op == 6'b000000)
                    fn = legal_fns[$urandom_range(0, 8)];
            end else if (sel == 10) begin
                op = 6'b000011;
            end else begin
                op = 6'($urandom);
            end
            run_inst(op, fn, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
